// File: rtl/ibex_ex_issue_ctrl_if.sv
// Issue and writeback handshake bundle for ibex_ex_issue_ctrl.
// Signal names keep the controller's point of view (_i = into the controller).
// The slave modport is used by the controller. The master modport is used by the
// ID/WB side that drives issues and consumes results.
interface ibex_ex_issue_ctrl_if;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic        issue_mult_i;
  logic        issue_div_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [31:0] wb_data_o;

  modport slave (
    input  issue_valid_i, issue_mult_i, issue_div_i, wb_ready_i,
    output issue_ready_o, wb_valid_o, wb_data_o
  );

  modport master (
    output issue_valid_i, issue_mult_i, issue_div_i, wb_ready_i,
    input  issue_ready_o, wb_valid_o, wb_data_o
  );
endinterface

// File: rtl/ibex_ex_issue_ctrl.sv
// ibex_ex_issue_ctrl: issue-side controller for the EX stage.
// The controller sequences one operation through IDLE -> EXEC -> HOLD.
// It drives the EX enables, selects and first-cycle strobe.
// It owns the two 34-bit intermediate registers.
// It holds the result in a registered writeback slot.
// Optional performance counters are enabled by defining IBEX_EX_ISSUE_PERF_EN.
// Without that macro, the counter ports read 0.
module ibex_ex_issue_ctrl #(
  parameter bit MultdivEnable = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ibex_ex_issue_ctrl_if.slave  bus,
  input  logic                 flush_i,
  input  logic                 ex_valid_i,
  input  logic [31:0]          result_ex_i,
  input  logic [1:0]           imd_val_we_i,
  input  logic [1:0][33:0]     imd_val_d_i,
  output logic [1:0][33:0]     imd_val_q_o,
  output logic                 alu_instr_first_cycle_o,
  output logic                 mult_en_o,
  output logic                 div_en_o,
  output logic                 mult_sel_o,
  output logic                 div_sel_o,
  output logic                 multdiv_ready_id_o,
  output logic [31:0]          perf_exec_cycles_o,
  output logic [31:0]          perf_ops_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       r_state;
  logic             r_mult;
  logic             r_div;
  logic             r_first;
  logic             r_wb_valid;
  logic [31:0]      r_wb_data;
  logic [1:0][33:0] r_imd;

  logic w_idle;
  logic w_exec;
  logic w_hold;
  logic w_issue_mult;
  logic w_issue_div;

  assign w_idle = (r_state == S_IDLE);
  assign w_exec = (r_state == S_EXEC);
  assign w_hold = (r_state == S_HOLD);

  // Multiply takes precedence when ID flags both kinds. Both are suppressed without multdiv support.
  assign w_issue_mult = bus.issue_mult_i & MultdivEnable;
  assign w_issue_div  = bus.issue_div_i & ~bus.issue_mult_i & MultdivEnable;

  // Sequence issue, execution and writeback. A flush kills the op but leaves the stale result data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_mult     <= 1'b0;
      r_div      <= 1'b0;
      r_first    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
    end else if (flush_i) begin
      r_state    <= S_IDLE;
      r_mult     <= 1'b0;
      r_div      <= 1'b0;
      r_first    <= 1'b0;
      r_wb_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.issue_valid_i) begin
            r_mult  <= w_issue_mult;
            r_div   <= w_issue_div;
            r_first <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_first <= 1'b0;
          if (ex_valid_i) begin
            r_wb_data  <= result_ex_i;
            r_wb_valid <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.wb_ready_i) begin
            r_wb_valid <= 1'b0;
            r_mult     <= 1'b0;
            r_div      <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Intermediate registers accept EX writes only while executing. Their contents survive across ops.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_imd <= '0;
    end else if (w_exec) begin
      for (int k = 0; k < 2; k++) begin
        if (imd_val_we_i[k]) begin
          r_imd[k] <= imd_val_d_i[k];
        end
      end
    end
  end

  assign bus.issue_ready_o = w_idle;
  assign bus.wb_valid_o    = r_wb_valid;
  assign bus.wb_data_o     = r_wb_data;

  assign imd_val_q_o             = r_imd;
  assign alu_instr_first_cycle_o = w_exec & r_first;
  assign mult_en_o               = w_exec & r_mult;
  assign div_en_o                = w_exec & r_div;
  assign mult_sel_o              = (w_exec | w_hold) & r_mult;
  assign div_sel_o               = (w_exec | w_hold) & r_div;
  assign multdiv_ready_id_o      = w_exec;

`ifdef IBEX_EX_ISSUE_PERF_EN
  logic [31:0] r_perf_exec;
  logic [31:0] r_perf_ops;

  // Count stall cycles past the first EXEC cycle and completed ops. Only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_exec <= '0;
      r_perf_ops  <= '0;
    end else begin
      if (w_exec && !r_first) begin
        r_perf_exec <= r_perf_exec + 32'd1;
      end
      if (w_exec && ex_valid_i && !flush_i) begin
        r_perf_ops <= r_perf_ops + 32'd1;
      end
    end
  end

  assign perf_exec_cycles_o = r_perf_exec;
  assign perf_ops_o         = r_perf_ops;
`else
  assign perf_exec_cycles_o = '0;
  assign perf_ops_o         = '0;
`endif

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// Testbench for ibex_ex_issue_ctrl. It runs two DUT copies from the same stimulus.
// Copy 0 has multdiv support enabled; copy 1 has it disabled.
// Each copy is checked every cycle against a behavioural model of the controller.
// A few hand-computed expectations pin down the model itself.
module tb_ibex_ex_issue_ctrl;

`ifdef IBEX_EX_ISSUE_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  localparam int KIND_ALU = 0;
  localparam int KIND_MUL = 1;
  localparam int KIND_DIV = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             issueValid, issueMult, issueDiv;
  logic             flush, exValid, wbReady;
  logic [31:0]      resultEx;
  logic [1:0]       imdWe;
  logic [1:0][33:0] imdD;

  logic             issueReady[2], firstCycle[2], multEn[2], divEn[2];
  logic             multSel[2], divSel[2], mdReady[2], wbValid[2];
  logic [31:0]      wbData[2], perfExec[2], perfOps[2];
  logic [1:0][33:0] imdQ[2];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : gDut
    ibex_ex_issue_ctrl_if ifc ();
    assign ifc.issue_valid_i = issueValid;
    assign ifc.issue_mult_i  = issueMult;
    assign ifc.issue_div_i   = issueDiv;
    assign ifc.wb_ready_i    = wbReady;
    assign issueReady[g]     = ifc.issue_ready_o;
    assign wbValid[g]        = ifc.wb_valid_o;
    assign wbData[g]         = ifc.wb_data_o;

    ibex_ex_issue_ctrl #(.MultdivEnable(g == 0)) dut (
      .clk_i                   (clk),
      .rst_i                   (rst),
      .bus                     (ifc.slave),
      .flush_i                 (flush),
      .ex_valid_i              (exValid),
      .result_ex_i             (resultEx),
      .imd_val_we_i            (imdWe),
      .imd_val_d_i             (imdD),
      .imd_val_q_o             (imdQ[g]),
      .alu_instr_first_cycle_o (firstCycle[g]),
      .mult_en_o               (multEn[g]),
      .div_en_o                (divEn[g]),
      .mult_sel_o              (multSel[g]),
      .div_sel_o               (divSel[g]),
      .multdiv_ready_id_o      (mdReady[g]),
      .perf_exec_cycles_o      (perfExec[g]),
      .perf_ops_o              (perfOps[g])
    );
  end

  // Behavioural model. Each copy tracks whether an op is executing and whether a result waits in
  // the writeback slot. It also tracks what kind of op is in flight.
  bit               mdSupported[2] = '{1'b1, 1'b0};
  bit               modelLive = 1'b0;
  bit               mExec[2], mPending[2], mFirst[2];
  int               mKind[2];
  logic [1:0][33:0] mImd[2];
  logic [31:0]      mWbData[2], mStall[2], mOps[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mExec[i] = 0; mPending[i] = 0; mFirst[i] = 0; mKind[i] = KIND_ALU;
        mImd[i] = '0; mWbData[i] = '0; mStall[i] = '0; mOps[i] = '0;
      end else begin
        if (mExec[i] && !mFirst[i]) mStall[i] = mStall[i] + 1;
        if (mExec[i] && exValid && !flush) mOps[i] = mOps[i] + 1;
        if (flush) begin
          mExec[i] = 0; mPending[i] = 0; mFirst[i] = 0; mKind[i] = KIND_ALU; mImd[i] = '0;
        end else if (mExec[i]) begin
          mFirst[i] = 0;
          if (imdWe[0]) mImd[i][0] = imdD[0];
          if (imdWe[1]) mImd[i][1] = imdD[1];
          if (exValid) begin
            mWbData[i] = resultEx;
            mExec[i] = 0;
            mPending[i] = 1;
          end
        end else if (mPending[i]) begin
          if (wbReady) mPending[i] = 0;
        end else if (issueValid) begin
          if (!mdSupported[i]) mKind[i] = KIND_ALU;
          else if (issueMult) mKind[i] = KIND_MUL;
          else if (issueDiv)  mKind[i] = KIND_DIV;
          else                mKind[i] = KIND_ALU;
          mExec[i] = 1;
          mFirst[i] = 1;
        end
      end
    end
    if (rst) modelLive = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output of both copies against the model on the falling edge.
  always @(negedge clk) begin
    if (modelLive) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("c%0d.issue_ready", i), 64'(issueReady[i]), 64'(!mExec[i] && !mPending[i]));
        checkOutput($sformatf("c%0d.first_cycle", i), 64'(firstCycle[i]), 64'(mExec[i] && mFirst[i]));
        checkOutput($sformatf("c%0d.mult_en", i), 64'(multEn[i]), 64'(mExec[i] && mKind[i] == KIND_MUL));
        checkOutput($sformatf("c%0d.div_en", i), 64'(divEn[i]), 64'(mExec[i] && mKind[i] == KIND_DIV));
        checkOutput($sformatf("c%0d.mult_sel", i), 64'(multSel[i]),
                    64'((mExec[i] || mPending[i]) && mKind[i] == KIND_MUL));
        checkOutput($sformatf("c%0d.div_sel", i), 64'(divSel[i]),
                    64'((mExec[i] || mPending[i]) && mKind[i] == KIND_DIV));
        checkOutput($sformatf("c%0d.md_ready", i), 64'(mdReady[i]), 64'(mExec[i]));
        checkOutput($sformatf("c%0d.wb_valid", i), 64'(wbValid[i]), 64'(mPending[i]));
        checkOutput($sformatf("c%0d.wb_data", i), 64'(wbData[i]), 64'(mWbData[i]));
        checkOutput($sformatf("c%0d.imd0", i), 64'(imdQ[i][0]), 64'(mImd[i][0]));
        checkOutput($sformatf("c%0d.imd1", i), 64'(imdQ[i][1]), 64'(mImd[i][1]));
        checkOutput($sformatf("c%0d.perf_exec", i), 64'(perfExec[i]), PerfOn ? 64'(mStall[i]) : 64'd0);
        checkOutput($sformatf("c%0d.perf_ops", i), 64'(perfOps[i]), PerfOn ? 64'(mOps[i]) : 64'd0);
      end
    end
  end

  task automatic setIdle();
    rst = 0; issueValid = 0; issueMult = 0; issueDiv = 0;
    flush = 0; exValid = 0; wbReady = 0; resultEx = '0; imdWe = '0; imdD = '0;
  endtask

  // One clock with the current inputs; returns 2 time units after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    setIdle();
    rst = 1;
    applyStimulus();
    applyStimulus();
    rst = 0;
  endtask

  int divCycles;

  // Directed scenarios first, then a randomized run.
  initial begin
    setIdle();
    doReset();
    checkOutput("rst.issue_ready", 64'(issueReady[0]), 64'd1);
    checkOutput("rst.wb_valid", 64'(wbValid[0]), 64'd0);
    checkOutput("rst.imd", 64'(imdQ[0][1]), 64'd0);

    // Single-cycle ALU op.
    issueValid = 1;
    applyStimulus();
    setIdle();
    checkOutput("alu.first", 64'(firstCycle[0]), 64'd1);
    checkOutput("alu.issue_ready", 64'(issueReady[0]), 64'd0);
    exValid = 1; resultEx = 32'h1234_5678; wbReady = 1;
    applyStimulus();
    exValid = 0;
    checkOutput("alu.first_gone", 64'(firstCycle[0]), 64'd0);
    checkOutput("alu.wb_valid", 64'(wbValid[0]), 64'd1);
    checkOutput("alu.wb_data", 64'(wbData[0]), 64'h1234_5678);
    applyStimulus();
    checkOutput("alu.wb_valid_drop", 64'(wbValid[0]), 64'd0);
    checkOutput("alu.issue_ready_back", 64'(issueReady[0]), 64'd1);

    // 37-cycle divide writing both intermediate registers every cycle.
    doReset();
    issueValid = 1; issueDiv = 1;
    applyStimulus();
    setIdle();
    divCycles = 0;
    for (int n = 1; n <= 37; n++) begin
      if (divEn[0] && divSel[0]) divCycles++;
      imdWe = 2'b11;
      imdD[0] = 34'h3_0000_0001;
      imdD[1] = 34'h3_0000_0001;
      exValid = (n == 37);
      resultEx = 32'hD1D1_0037;
      applyStimulus();
    end
    setIdle();
    checkOutput("div.en_cycles", 64'(divCycles), 64'd37);
    checkOutput("div.en_off", 64'(divEn[0]), 64'd0);
    checkOutput("div.sel_held", 64'(divSel[0]), 64'd1);
    checkOutput("div.imd0", 64'(imdQ[0][0]), 64'h3_0000_0001);
    checkOutput("div.imd1", 64'(imdQ[0][1]), 64'h3_0000_0001);
    checkOutput("div.perf_exec", 64'(perfExec[0]), PerfOn ? 64'd36 : 64'd0);
    checkOutput("div.perf_ops", 64'(perfOps[0]), PerfOn ? 64'd1 : 64'd0);

    // Back-pressure in HOLD: the result stays put and intermediate writes are ignored.
    for (int n = 0; n < 5; n++) begin
      wbReady = 0;
      imdWe = 2'b11;
      imdD[0] = 34'h0_5555_AAAA;
      imdD[1] = 34'h2_AAAA_5555;
      applyStimulus();
      checkOutput("hold.wb_valid", 64'(wbValid[0]), 64'd1);
      checkOutput("hold.wb_data", 64'(wbData[0]), 64'hD1D1_0037);
      checkOutput("hold.issue_ready", 64'(issueReady[0]), 64'd0);
      checkOutput("hold.imd0", 64'(imdQ[0][0]), 64'h3_0000_0001);
    end
    setIdle();
    wbReady = 1;
    applyStimulus();
    setIdle();
    checkOutput("hold.release", 64'(issueReady[0]), 64'd1);

    // Multiply flushed in its 4th EXEC cycle while EX also reports a result.
    issueValid = 1; issueMult = 1;
    applyStimulus();
    setIdle();
    for (int n = 1; n <= 3; n++) begin
      checkOutput("mul.en", 64'(multEn[0]), 64'd1);
      checkOutput("mul.en_nomd", 64'(multEn[1]), 64'd0);
      imdWe = 2'b01; imdD[0] = 34'h1_0000_00F0;
      applyStimulus();
    end
    flush = 1; exValid = 1; resultEx = 32'hBAD0_BAD0;
    applyStimulus();
    setIdle();
    checkOutput("flush.issue_ready", 64'(issueReady[0]), 64'd1);
    checkOutput("flush.wb_valid", 64'(wbValid[0]), 64'd0);
    checkOutput("flush.imd0", 64'(imdQ[0][0]), 64'd0);
    checkOutput("flush.mult_en", 64'(multEn[0]), 64'd0);

    // Both kinds flagged: only multiply asserts; the copy without multdiv runs it as ALU.
    issueValid = 1; issueMult = 1; issueDiv = 1;
    applyStimulus();
    setIdle();
    checkOutput("both.mult_en", 64'(multEn[0]), 64'd1);
    checkOutput("both.div_en", 64'(divEn[0]), 64'd0);
    checkOutput("nomd.mult_sel", 64'(multSel[1]), 64'd0);
    exValid = 1; resultEx = 32'h0000_ABCD;
    applyStimulus();
    setIdle();
    checkOutput("nomd.wb_valid", 64'(wbValid[1]), 64'd1);
    checkOutput("nomd.wb_data", 64'(wbData[1]), 64'h0000_ABCD);
    wbReady = 1;
    applyStimulus();
    setIdle();

    // Randomized traffic, checked by the model on every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      issueValid = $urandom_range(0, 1) == 1;
      issueMult  = $urandom_range(0, 2) == 0;
      issueDiv   = $urandom_range(0, 2) == 0;
      flush      = ($urandom_range(0, 24) == 0);
      exValid    = ($urandom_range(0, 3) == 0);
      wbReady    = ($urandom_range(0, 2) != 0);
      resultEx   = $urandom;
      imdWe      = 2'($urandom_range(0, 3));
      imdD[0]    = {2'($urandom_range(0, 3)), 32'($urandom)};
      imdD[1]    = {2'($urandom_range(0, 3)), 32'($urandom)};
      applyStimulus();
    end
    setIdle();
    applyStimulus();
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
